// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code width, legal function codes and a
// helper that tells legal codes from illegal ones (011 and 111).
package alu_pkg;

  localparam int ALU_FUNC_W = 3;

  localparam logic [ALU_FUNC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 3'b100;
  localparam logic [ALU_FUNC_W-1:0] ALU_MUL = 3'b101;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT = 3'b110;

  function automatic logic is_legal_func(input logic [ALU_FUNC_W-1:0] f);
    logic ok;
    case (f)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter.
//  A, B      : operands (DATA_W)
//  ALU_FUNC  : function code (ALU_FUNC_W)
//  ALU_OUT   : result, wrap-around; 0 for illegal codes
//  Zero_Flag : ALU_OUT == 0
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [ALU_FUNC_W-1:0] ALU_FUNC,
  output logic [DATA_W-1:0]     ALU_OUT,
  output logic                  Zero_Flag
);

  always_comb begin
    ALU_OUT = '0;
    case (ALU_FUNC)
      ALU_AND: ALU_OUT = A & B;
      ALU_OR:  ALU_OUT = A | B;
      ALU_ADD: ALU_OUT = A + B;
      ALU_SUB: ALU_OUT = A - B;
      ALU_MUL: ALU_OUT = A * B;            // low DATA_W bits of the product
      ALU_SLT: ALU_OUT = {{(DATA_W-1){1'b0}}, (A < B)};  // unsigned compare
      default: ALU_OUT = '0;
    endcase
  end

  assign Zero_Flag = (ALU_OUT == '0);

endmodule

// File: rtl/alu_rr_arbiter_alu.sv
// Execution slice of the arbiter: wraps the shared ALU and flags illegal
// function codes locally.
//  a, b, func : operands and function of the granted requester
//  result     : ALU result (0 for illegal codes)
//  zero       : result == 0
//  ill        : func is not a defined ALU operation
module alu_rr_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic [ALU_FUNC_W-1:0] func,
  output logic [DATA_W-1:0]     result,
  output logic                  zero,
  output logic                  ill
);

  alu #(.DATA_W(DATA_W)) u_alu (
    .A         (a),
    .B         (b),
    .ALU_FUNC  (func),
    .ALU_OUT   (result),
    .Zero_Flag (zero)
  );

  assign ill = !is_legal_func(func);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters. One request is
// granted per cycle; its result, zero flag, illegal flag and requester ID are
// captured in a single output register drained by valid/ready.
//  clk, rst_n                 : clock, async active-low reset
//  req_valid/req_ready        : per-requester handshake (one-hot ready)
//  req_a, req_b, req_func     : packed per-requester operands / function code
//  rsp_valid/rsp_ready        : result register handshake
//  rsp_data/zero/id/ill       : registered result fields
//  busy                       : any request pending or result held
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DATA_W-1:0]       req_a,
  input  logic [N_REQ*DATA_W-1:0]       req_b,
  input  logic [N_REQ*ALU_FUNC_W-1:0]   req_func,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_zero,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_ill,
  output logic                          busy
);

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       win;
  logic [ID_W-1:0]       next_ptr;
  logic                  found;
  logic                  can_acc;
  logic                  acc;
  logic [DATA_W-1:0]     a_sel;
  logic [DATA_W-1:0]     b_sel;
  logic [ALU_FUNC_W-1:0] f_sel;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_zero;
  logic                  alu_ill;

  // Rotating priority search: first valid requester at or above rr_ptr,
  // wrapping past N_REQ-1. The index is folded by subtraction so N_REQ need
  // not be a power of two.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign can_acc = !rsp_valid || rsp_ready;
  // Gating with rst_n keeps every ready low while reset is held.
  assign acc     = rst_n && found && can_acc;

  always_comb begin
    req_ready = '0;
    if (acc) req_ready[win] = 1'b1;
  end

  assign a_sel = req_a[int'(win)*DATA_W +: DATA_W];
  assign b_sel = req_b[int'(win)*DATA_W +: DATA_W];
  assign f_sel = req_func[int'(win)*ALU_FUNC_W +: ALU_FUNC_W];

  alu_rr_arbiter_alu #(.DATA_W(DATA_W)) u_exe (
    .a      (a_sel),
    .b      (b_sel),
    .func   (f_sel),
    .result (alu_res),
    .zero   (alu_zero),
    .ill    (alu_ill)
  );

  assign next_ptr = (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
      rsp_ill   <= 1'b0;
      rr_ptr    <= '0;
    end else if (acc) begin
      // Covers accept-with-drain too: the register is simply overwritten.
      rsp_valid <= 1'b1;
      rsp_data  <= alu_res;
      rsp_zero  <= alu_zero;
      rsp_id    <= win;
      rsp_ill   <= alu_ill;
      rr_ptr    <= next_ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;   // drain only; payload left as-is
    end
  end

  assign busy = (req_valid != '0) || rsp_valid;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a, req_b;
  logic [N*3-1:0]    req_func;
  logic              rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_zero, rsp_ill, busy;
  logic [IW-1:0]     rsp_id;

  alu_rr_arbiter #(.N_REQ(N), .ID_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_func(req_func),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_id(rsp_id), .rsp_ill(rsp_ill), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the held result and the round-robin start position.
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_zero, m_ill;
  int          m_id;
  int          last_grant;
  int          grants[$];

  function automatic logic [31:0] ref_alu(input logic [31:0] a, b, input logic [2:0] f);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd4: return a - b;
      3'd5: return p[31:0];
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [31:0] a, b, input logic [2:0] f);
    req_valid[i]          = v;
    req_a[i*DW +: DW]     = a;
    req_b[i*DW +: DW]     = b;
    req_func[i*3 +: 3]    = f;
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One clock: check everything visible at the negedge against the model,
  // then advance the model across the posedge. Returns at posedge+1.
  task automatic cycle();
    int w;
    bit can;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    w   = model_winner();
    can = !m_valid || rsp_ready;
    exp_rdy = '0;
    if (w >= 0 && can) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'((req_valid != 0) || m_valid));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_ill", 64'(rsp_ill), 64'(m_ill));
    end
    last_grant = -1;
    if (w >= 0 && can) begin
      m_valid = 1;
      m_data  = ref_alu(req_a[w*DW +: DW], req_b[w*DW +: DW], req_func[w*3 +: 3]);
      m_zero  = (m_data == 0);
      m_ill   = (req_func[w*3 +: 3] == 3'd3) || (req_func[w*3 +: 3] == 3'd7);
      m_id    = w;
      m_ptr   = (w + 1) % N;
      last_grant = w;
      grants.push_back(w);
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Single request from requester i, withdrawn once accepted.
  task automatic one_op(input int i, input logic [31:0] a, b, input logic [2:0] f);
    set_req(i, 1, a, b, f);
    cycle();
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int exp_order[8];
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_func = '0; rsp_ready = 1'b0;
    m_ptr = 0; m_valid = 0; m_data = 0; m_zero = 0; m_ill = 0; m_id = 0; last_grant = -1;
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester ADD 7+5 -> 12, id 2
    rsp_ready = 1'b1;
    one_op(2, 32'd7, 32'd5, 3'b010);
    chk("t2_valid", 64'(rsp_valid), 64'd1);
    chk("t2_data", 64'(rsp_data), 64'd12);
    chk("t2_id", 64'(rsp_id), 64'd2);
    chk("t2_zero", 64'(rsp_zero), 64'd0);
    cycle();

    // Reset while a result is held and a request is pending
    rsp_ready = 1'b0;
    one_op(1, 32'd3, 32'd4, 3'b010);
    set_req(3, 1, 32'd1, 32'd1, 3'b010);
    #3; rst_n = 1'b0; #1;
    chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    m_ptr = 0; m_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fairness: all four continuously valid, order must start at 0
    rsp_ready = 1'b1;
    grants.delete();
    for (int i = 0; i < N; i++) set_req(i, 1, 32'(i), 32'd1, 3'b010);
    for (int c = 0; c < 8; c++) cycle();
    chk("fair_count", 64'(grants.size()), 64'd8);
    for (int c = 0; c < 8 && c < grants.size(); c++)
      chk($sformatf("fair_grant%0d", c), 64'(grants[c]), 64'(exp_order[c]));
    req_valid = '0;
    cycle();

    // Backpressure: SUB 9-9 held, next op waits, then accept+drain together
    rsp_ready = 1'b0;
    one_op(1, 32'd9, 32'd9, 3'b100);
    set_req(2, 1, 32'd1, 32'd2, 3'b010);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_data", 64'(rsp_data), 64'd0);
      chk("bp_zero", 64'(rsp_zero), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd1);
    end
    rsp_ready = 1'b1;
    cycle();
    req_valid[2] = 1'b0;
    chk("bp_same_cycle_valid", 64'(rsp_valid), 64'd1);
    chk("bp_same_cycle_data", 64'(rsp_data), 64'd3);
    chk("bp_same_cycle_id", 64'(rsp_id), 64'd2);

    // Arithmetic edges
    one_op(0, 32'hFFFF_FFFF, 32'd1, 3'b010);
    chk("add_wrap_data", 64'(rsp_data), 64'd0);
    chk("add_wrap_zero", 64'(rsp_zero), 64'd1);
    one_op(0, 32'h0001_0000, 32'h0001_0000, 3'b101);
    chk("mul_wrap_data", 64'(rsp_data), 64'd0);
    one_op(0, 32'd1, 32'hFFFF_FFFF, 3'b110);
    chk("slt_unsigned", 64'(rsp_data), 64'd1);
    one_op(0, 32'h1234, 32'h5678, 3'b111);
    chk("ill_flag", 64'(rsp_ill), 64'd1);
    chk("ill_data", 64'(rsp_data), 64'd0);
    chk("ill_zero", 64'(rsp_zero), 64'd1);

    // Wrap: move pointer to 3, then req 3 beats req 0
    one_op(2, 32'd0, 32'd0, 3'b000);
    set_req(0, 1, 32'd10, 32'd1, 3'b010);
    set_req(3, 1, 32'd20, 32'd1, 3'b010);
    cycle();
    chk("wrap_first", 64'(last_grant), 64'd3);
    req_valid[3] = 1'b0;
    cycle();
    chk("wrap_second", 64'(last_grant), 64'd0);
    req_valid[0] = 1'b0;
    cycle();

    // Randomized traffic: requesters hold payload until granted
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          logic [31:0] ra, rb;
          ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
          set_req(i, 1, ra, rb, 3'($urandom_range(0, 7)));
        end
      cycle();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
